// File: rtl/alu_pkg.sv
// Shared types for the ALU operand sequencer: sequencer states, op codes and the
// default data width.
package alu_pkg;
  localparam int ALU_DATA_W = 8;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;
endpackage

// File: rtl/alu_operand_sequencer_stb_sync_edge.sv
// Synchronises the asynchronous strobe pin and turns its rising edge into a
// single-cycle pulse. The whole chain freezes while ena is low.
module stb_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic async_in,
  output logic pulse_out
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_edge <= 1'b0;
    end else if (ena) begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_edge <= r_sync[SYNC_STAGES-1];
    end
  end

  assign pulse_out = r_sync[SYNC_STAGES-1] & ~r_edge;
endmodule

// File: rtl/alu_operand_sequencer.sv
// Collects A, B and the op selector byte-by-byte from one bus, holds them stable
// for the combinational ALU and captures its result one cycle later.
module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W      = ALU_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [DATA_W-1:0] din,
  input  logic              din_stb,
  input  logic              clr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] res,
  output logic              res_valid,
  output logic              busy,
  output logic [2:0]        state_dbg
);
  state_e            r_state;
  logic [DATA_W-1:0] r_a, r_b, r_res;
  logic [1:0]        r_sel;
  logic              r_vld;
  logic              w_stb;

  stb_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_stb (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .async_in (din_stb),
    .pulse_out(w_stb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_A;
      r_a     <= '0;
      r_b     <= '0;
      r_sel   <= '0;
      r_res   <= '0;
      r_vld   <= 1'b0;
    end else if (ena) begin
      if (clr) begin
        // abort wins over a coincident strobe, which is dropped
        r_state <= S_A;
        r_a     <= '0;
        r_b     <= '0;
        r_sel   <= '0;
        r_res   <= '0;
        r_vld   <= 1'b0;
      end else begin
        case (r_state)
          S_A: if (w_stb) begin
            r_a     <= din;
            r_state <= S_B;
          end
          S_B: if (w_stb) begin
            r_b     <= din;
            r_state <= S_OP;
          end
          S_OP: if (w_stb) begin
            r_sel   <= din[1:0];
            r_state <= S_EXEC;
          end
          S_EXEC: begin
            r_res   <= alu_result;
            r_vld   <= 1'b1;
            r_state <= S_DONE;
          end
          S_DONE: if (w_stb) begin
            // next byte after a finished op starts a fresh sequence as operand A
            r_a     <= din;
            r_vld   <= 1'b0;
            r_state <= S_B;
          end
          default: r_state <= S_A;
        endcase
      end
    end
  end

  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_sel   = r_sel;
  assign res       = r_res;
  assign res_valid = r_vld;
  assign busy      = (r_state == S_B) || (r_state == S_OP) || (r_state == S_EXEC);
  assign state_dbg = r_state;
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a transaction-level reference
// model compared every cycle, plus literal spot checks.
module tb_alu_operand_sequencer;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n, ena, din_stb, clr;
  logic [7:0] din, alu_a, alu_b, alu_result, res;
  logic [1:0] alu_sel;
  logic       res_valid, busy;
  logic [2:0] state_dbg;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  alu_operand_sequencer #(.DATA_W(8), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .din(din), .din_stb(din_stb), .clr(clr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
    .res(res), .res_valid(res_valid), .busy(busy), .state_dbg(state_dbg)
  );

  // external combinational ALU
  function automatic logic [7:0] alu_fn(input logic [7:0] a, b, input logic [1:0] s);
    case (s)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction
  assign alu_result = alu_fn(alu_a, alu_b, alu_sel);

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: phase 0..4 = waiting A, B, op, executing, done
  int         m_ph;
  logic [7:0] m_a, m_b, m_res;
  logic [1:0] m_sel;
  logic       m_vld;
  int         m_cnt;
  bit         m_prev;
  int         act_q[$];

  task automatic model_reset();
    m_ph = 0; m_a = 0; m_b = 0; m_sel = 0; m_res = 0; m_vld = 0;
    m_cnt = 0; m_prev = 0; act_q.delete();
  endtask

  task automatic model_step();
    bit act;
    act = 0;
    m_cnt++;
    // a rise seen at enabled edge k takes effect at enabled edge k+SYNC
    if (act_q.size() > 0 && act_q[0] == m_cnt) begin
      act = 1;
      void'(act_q.pop_front());
    end
    if (din_stb && !m_prev) act_q.push_back(m_cnt + SYNC);
    m_prev = din_stb;
    if (clr) begin
      m_ph = 0; m_a = 0; m_b = 0; m_sel = 0; m_res = 0; m_vld = 0;
    end else begin
      case (m_ph)
        0: if (act) begin m_a = din; m_ph = 1; end
        1: if (act) begin m_b = din; m_ph = 2; end
        2: if (act) begin m_sel = din[1:0]; m_ph = 3; end
        3: begin m_res = alu_fn(m_a, m_b, m_sel); m_vld = 1; m_ph = 4; end
        default: if (act) begin m_a = din; m_vld = 0; m_ph = 1; end
      endcase
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else if (ena) model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && rst_n) begin
        check("cyc_state", {5'd0, state_dbg}, m_ph[7:0]);
        check("cyc_alu_a", alu_a, m_a);
        check("cyc_alu_b", alu_b, m_b);
        check("cyc_alu_sel", {6'd0, alu_sel}, {6'd0, m_sel});
        check("cyc_res", res, m_res);
        check("cyc_res_valid", {7'd0, res_valid}, {7'd0, m_vld});
        check("cyc_busy", {7'd0, busy}, {7'd0, (m_ph >= 1 && m_ph <= 3)});
      end
    end
  end

  // raise the strobe with a byte; returns just after the edge where it acts
  task automatic send(input logic [7:0] b, input bit clr_act);
    din = b; din_stb = 1'b1;
    repeat (SYNC) @(posedge clk);
    #2 clr = clr_act;
    @(posedge clk); #2;
    clr = 1'b0; din_stb = 1'b0;
  endtask

  task automatic gap();
    repeat (SYNC + 2) @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 0; ena = 1; din = 0; din_stb = 0; clr = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    check("rst_state", {5'd0, state_dbg}, 8'd0);
    check("rst_valid", {7'd0, res_valid}, 8'd0);
    chk_en = 1;

    // basic add
    send(8'h25, 0); check("add_a_state", {5'd0, state_dbg}, 8'd1); check("add_a", alu_a, 8'h25); gap();
    send(8'h13, 0); check("add_b", alu_b, 8'h13); gap();
    send(8'h00, 0);
    check("add_exec_state", {5'd0, state_dbg}, 8'd3);
    check("add_exec_valid", {7'd0, res_valid}, 8'd0);
    @(posedge clk); #2;
    check("add_res", res, 8'h38);
    check("add_valid", {7'd0, res_valid}, 8'd1);
    check("add_sel", {6'd0, alu_sel}, 8'd0);
    gap();

    // back-to-back from done
    send(8'h0F, 0);
    check("b2b_state", {5'd0, state_dbg}, 8'd1);
    check("b2b_a", alu_a, 8'h0F);
    check("b2b_valid", {7'd0, res_valid}, 8'd0);
    gap(); send(8'h01, 0); gap(); send(8'h01, 0);
    @(posedge clk); #2;
    check("sub_res", res, 8'h0E);
    gap();

    // clr coincident with a strobe in S_B
    send(8'h55, 0); gap();
    send(8'h66, 1);
    check("clr_state", {5'd0, state_dbg}, 8'd0);
    check("clr_a", alu_a, 8'h00);
    check("clr_b", alu_b, 8'h00);
    check("clr_valid", {7'd0, res_valid}, 8'd0);
    gap();

    // strobe pulse entirely inside ena=0 is lost
    send(8'h77, 0); gap();
    ena = 0; din = 8'h99; din_stb = 1;
    repeat (5) @(posedge clk);
    #2 din_stb = 0;
    repeat (3) @(posedge clk);
    #2 ena = 1;
    repeat (6) @(posedge clk);
    #2;
    check("ena_state", {5'd0, state_dbg}, 8'd1);
    check("ena_a", alu_a, 8'h77);
    check("ena_b", alu_b, 8'h00);

    // op byte upper bits ignored
    clr = 1; @(posedge clk); #2 clr = 0;
    send(8'h12, 0); gap(); send(8'h34, 0); gap(); send(8'hFE, 0);
    @(posedge clk); #2;
    check("mask_sel", {6'd0, alu_sel}, 8'd2);
    check("mask_a", alu_a, 8'h12);
    check("mask_b", alu_b, 8'h34);
    check("mask_res", res, 8'h10);
    gap();

    // async reset in the middle of S_OP
    send(8'hAB, 0); gap(); send(8'hCD, 0); gap();
    check("pre_rst_state", {5'd0, state_dbg}, 8'd2);
    #1 rst_n = 0;
    #1;
    check("arst_state", {5'd0, state_dbg}, 8'd0);
    check("arst_res", res, 8'h00);
    check("arst_valid", {7'd0, res_valid}, 8'd0);
    check("arst_busy", {7'd0, busy}, 8'd0);
    check("arst_a", alu_a, 8'h00);
    check("arst_b", alu_b, 8'h00);
    rst_n = 1;
    repeat (3) @(posedge clk);
    #2;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
- Upstream stage of the 8-bit ALU in the Tiny Tapeout top.
- Collects operand A, operand B and the 2-bit op selector, byte by byte, from the single 8-bit input bus using an external strobe pin.
- Presents the stable A, B and selector to the combinational ALU, then captures and holds the ALU result.
- Frees the ALU from the constraint that A, B and selector share one input byte.

Parameters:
- DATA_W, 8: operand/result width.
- SYNC_STAGES, 2: flops in the strobe synchronizer; minimum 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  design enable; when low, every register holds
- din  input  DATA_W  byte bus (A, B or op byte)
- din_stb  input  1  asynchronous load strobe pin; rising edge loads din
- clr  input  1  synchronous abort (qualified by ena)
- alu_a  output  DATA_W  operand A to ALU
- alu_b  output  DATA_W  operand B to ALU
- alu_sel  output  2  op selector to ALU
- alu_result  input  DATA_W  combinational ALU result
- res  output  DATA_W  captured result
- res_valid  output  1  res holds a fresh result
- busy  output  1  sequence in progress
- state_dbg  output  3  current FSM state encoding

Behaviour:
- Reset (async, rst_n=0):
  - state=S_A.
  - a_reg, b_reg, sel_reg, res_reg = 0; res_valid = 0.
  - Sync chain and edge register = 0.
- Strobe path:
  - din_stb passes through SYNC_STAGES flops, then one edge register.
  - stb_p = sync_last & ~edge_reg, a one-cycle pulse.
  - If din_stb rises before edge k, stb_p is high in the cycle after edge k+SYNC_STAGES-1 and acts at edge k+SYNC_STAGES.
  - din is sampled on the same edge stb_p acts on. The driver holds din stable from strobe rise until SYNC_STAGES+1 cycles later.
- ena=0: all registers, including the sync chain, hold. Strobe edges occurring while ena=0 are lost.
- FSM encoding: S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_DONE=4. Codes 5–7 are illegal and go to S_A.
- S_A: on stb_p, a_reg<=din, go to S_B.
- S_B: on stb_p, b_reg<=din, go to S_OP.
- S_OP: on stb_p, sel_reg<=din[1:0] (din[7:2] ignored), go to S_EXEC.
- S_EXEC: lasts exactly one cycle, unconditionally.
  - res_reg<=alu_result; res_valid<=1; go to S_DONE.
  - stb_p in S_EXEC is ignored. It cannot occur, since pulses are at least 2 cycles apart.
- S_DONE: res and res_valid hold indefinitely.
  - On stb_p: a_reg<=din, res_valid<=0, go to S_B. This is a back-to-back sequence; the new byte is operand A.
- clr:
  - Applies when ena=1 and clr=1, in any state.
  - Next state S_A; a_reg, b_reg, sel_reg, res_reg and res_valid cleared.
  - Has priority over a simultaneous stb_p; that strobe is discarded.
- Outputs:
  - alu_a=a_reg, alu_b=b_reg, alu_sel=sel_reg, res=res_reg, all driven directly from registers.
  - busy = (state ∈ {S_B, S_OP, S_EXEC}), combinational from state.
  - state_dbg = state.
- Latency: from the op-byte stb_p edge to res_valid high is 2 clk edges (S_OP→S_EXEC, then S_EXEC→S_DONE).
- Arithmetic: none in this block. Widths pass through unchanged.
- Reset mid-sequence: immediate return to reset values. Any partial operands are discarded.

Decomposition:
- Shared package alu_pkg holds:
  - DATA_W default.
  - State encodings S_A..S_DONE (3-bit).
  - Op codes: OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11.
- One natural sub-module: stb_sync_edge.
  - Parameter SYNC_STAGES.
  - Ports clk, rst_n, ena, async_in, pulse_out.

Test Plan:
- Reset: rst_n=0 mid-S_OP → state_dbg=0, res=0x00, res_valid=0, busy=0, alu_a=alu_b=0x00 asynchronously.
- Basic add: strobes with din=0x25, 0x13, 0x00 (model ALU adds) → alu_a=0x25, alu_b=0x13, alu_sel=00; res=0x38 and res_valid=1 exactly 2 edges after the third stb_p.
- Back-to-back: from S_DONE (res=0x38), strobe 0x0F → res_valid=0, alu_a=0x0F, state_dbg=1. Then 0x01 and op 0x01 (sub) → res=0x0E.
- clr priority: clr=1 on the same edge as stb_p in S_B → state_dbg=0, alu_a=0x00, b_reg unchanged-cleared=0x00, res_valid=0.
- ena gating: ena=0 while din_stb pulses high for 5 cycles and returns low → no state change. With ena=1 and a held-high strobe raised during ena=0 → no load.
- Op byte masking: op byte din=0xFE → alu_sel=2'b10; upper bits have no effect on alu_a or alu_b.
